math_game_judge: RTL and testbench

Answer-checking end of the mental-math game. It consumes the stream of random operands the game controller displays and accumulates their sum. It then captures the player's switch entry on a synchronized submit press, judges it correct, wrong or timed-out, and maintains a saturating score shown as an LED thermometer bar. It sits beside the game controller, sharing its clock, reset, operand bus and switch bank.

---
 rtl/math_game_judge.sv | 134 +++++++++++++
 tb/tb_math_game_judge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/math_game_judge.sv
// rtl/math_game_judge.sv - answer judge for the mental-math game
// Sums a round's operands, captures and judges the player's answer, and keeps a saturating score.
module math_game_judge #(
  parameter int NUM_COUNT = 5,
  parameter int MAX_SCORE = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       round_start,
  input  logic       num_valid,
  input  logic [4:0] num_in,
  input  logic       answer_window,
  input  logic [7:0] answer_in,
  input  logic       submit,
  output logic [7:0] round_sum,
  output logic [7:0] answer_latched,
  output logic       result_valid,
  output logic       correct,
  output logic       timeout,
  output logic [2:0] score,
  output logic [6:0] score_led,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WAIT_ANS,
    S_CHECK,
    S_RESULT
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_COUNT - 1);
  localparam logic [2:0] MAX_L    = 3'(MAX_SCORE);

  state_t     state_q, state_d;
  logic [7:0] round_sum_q, round_sum_d;
  logic [3:0] count_q, count_d;
  logic [7:0] answer_q, answer_d;
  logic       correct_q, correct_d;
  logic       timeout_q, timeout_d;
  logic [2:0] score_q, score_d;
  logic       sync1_q, sync2_q, sync3_q;
  logic       submit_edge;

  // sync1/sync2 resynchronise the button; sync3 delays it for rising-edge detection
  assign submit_edge = sync2_q & ~sync3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      round_sum_q <= 8'd0;
      count_q     <= 4'd0;
      answer_q    <= 8'd0;
      correct_q   <= 1'b0;
      timeout_q   <= 1'b0;
      score_q     <= 3'd0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_sum_q <= round_sum_d;
      count_q     <= count_d;
      answer_q    <= answer_d;
      correct_q   <= correct_d;
      timeout_q   <= timeout_d;
      score_q     <= score_d;
      sync1_q     <= submit;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    round_sum_d = round_sum_q;
    count_d     = count_q;
    answer_d    = answer_q;
    correct_d   = correct_q;
    timeout_d   = timeout_q;
    score_d     = score_q;
    // round_start restarts from any state and discards a coincident operand
    if (round_start) begin
      round_sum_d = 8'd0;
      count_d     = 4'd0;
      answer_d    = 8'd0;
      correct_d   = 1'b0;
      timeout_d   = 1'b0;
      state_d     = S_COLLECT;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_COLLECT: begin
          if (num_valid) begin
            round_sum_d = round_sum_q + {3'b000, num_in};
            count_d     = count_q + 4'd1;
            if (count_q == LAST_IDX) state_d = S_WAIT_ANS;
          end
        end
        S_WAIT_ANS: begin
          if (submit_edge) begin
            answer_d = answer_in;
            state_d  = S_CHECK;
          end else if (!answer_window) begin
            timeout_d = 1'b1;
            state_d   = S_CHECK;
          end
        end
        S_CHECK: begin
          correct_d = (answer_q == round_sum_q) && !timeout_q;
          if (correct_d) begin
            score_d = (score_q == MAX_L) ? score_q : score_q + 3'd1;
          end else begin
            score_d = (score_q == 3'd0) ? score_q : score_q - 3'd1;
          end
          state_d = S_RESULT;
        end
        S_RESULT: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  assign round_sum      = round_sum_q;
  assign answer_latched = answer_q;
  assign result_valid   = (state_q == S_RESULT);
  assign correct        = correct_q;
  assign timeout        = timeout_q;
  assign score          = score_q;
  assign score_led      = 7'((8'd1 << score_q) - 8'd1);
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_math_game_judge.sv
// tb/tb_math_game_judge.sv - scoreboard bench for math_game_judge
// Stimulus pushes expected verdicts; a negedge monitor pops and checks each result_valid pulse.
module tb_math_game_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic       round_start, num_valid, answer_window, submit;
  logic [4:0] num_in;
  logic [7:0] answer_in;
  logic [7:0] round_sum, answer_latched;
  logic       result_valid, correct, timeout, busy;
  logic [2:0] score;
  logic [6:0] score_led;

  math_game_judge #(.NUM_COUNT(5), .MAX_SCORE(7)) dut (
    .clk(clk), .rst(rst), .round_start(round_start), .num_valid(num_valid),
    .num_in(num_in), .answer_window(answer_window), .answer_in(answer_in),
    .submit(submit), .round_sum(round_sum), .answer_latched(answer_latched),
    .result_valid(result_valid), .correct(correct), .timeout(timeout),
    .score(score), .score_led(score_led), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int corr;
    int to;
    int sc;
    int ans;
    int sum;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_res = 0;
  int   cyc = 0;
  int   exp_score = 0;

  int ops_t [6][5] = '{
    '{3, 17, 31, 0, 9},
    '{31, 31, 31, 31, 31},
    '{1, 2, 3, 4, 5},
    '{0, 0, 0, 0, 0},
    '{10, 20, 30, 5, 1},
    '{5, 6, 7, 8, 9}
  };
  int sum_t [6] = '{60, 155, 15, 0, 66, 35};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && result_valid) begin
      exp_t e;
      n_res++;
      if (sb.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("res_cycle", cyc, e.cyc);
        chk("res_correct", int'(correct), e.corr);
        chk("res_timeout", int'(timeout), e.to);
        chk("res_score", int'(score), e.sc);
        chk("res_answer_latched", int'(answer_latched), e.ans);
        chk("res_round_sum", int'(round_sum), e.sum);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int corr, input int to, input int ans, input int sum, input int at);
    exp_t e;
    if (corr != 0) exp_score = (exp_score == 7) ? 7 : exp_score + 1;
    else           exp_score = (exp_score == 0) ? 0 : exp_score - 1;
    e.corr = corr; e.to = to; e.sc = exp_score; e.ans = ans; e.sum = sum; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic start_round();
    round_start = 1'b1;
    tick();
    round_start = 1'b0;
  endtask

  task automatic send_ops(input int v, input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      num_valid = 1'b1;
      num_in    = 5'(ops_t[v][i]);
      tick();
    end
    num_valid = 1'b0;
  endtask

  task automatic collect(input int v);
    start_round();
    send_ops(v, 0, 5);
    chk("collect_sum", int'(round_sum), sum_t[v]);
  endtask

  task automatic wait_res(input int target);
    for (int i = 0; i < 30 && n_res < target; i++) tick();
    chk("result_arrived", int'(n_res >= target), 1);
  endtask

  task automatic press(input int ans, input int hold, input int sum);
    int tgt;
    tgt = n_res + 1;
    answer_in = 8'(ans);
    push_exp(int'(ans == sum), 0, ans, sum, cyc + 4);
    submit = 1'b1;
    for (int i = 0; i < hold; i++) tick();
    submit = 1'b0;
    wait_res(tgt);
    tick(); tick(); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt;
    rst = 1'b1; round_start = 1'b0; num_valid = 1'b0; num_in = 5'd0;
    answer_window = 1'b1; answer_in = 8'd0; submit = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_round_sum", int'(round_sum), 0);
    chk("reset_answer", int'(answer_latched), 0);
    chk("reset_flags", int'({result_valid, correct, timeout, busy}), 0);
    chk("reset_score", int'(score), 0);
    chk("reset_led", int'(score_led), 0);

    // correct answer, button held 5 cycles
    collect(0);
    chk("busy_in_round", int'(busy), 1);
    press(60, 5, 60);
    chk("led_score1", int'(score_led), 7'b0000001);
    chk("correct_held", int'(correct), 1);
    chk("idle_after_result", int'(busy), 0);

    // wrong answers, floor at 0
    collect(0); press(59, 2, 60);
    collect(0); press(59, 2, 60);
    chk("score_floor", int'(score), 0);

    // eight correct rounds, ceiling at 7
    for (int k = 0; k < 8; k++) begin
      collect(k % 5);
      press(sum_t[k % 5], 3, sum_t[k % 5]);
    end
    chk("score_ceiling", int'(score), 7);
    chk("led_full", int'(score_led), 7'b1111111);

    // four wrong rounds bring score to 3
    for (int k = 0; k < 4; k++) begin
      collect(2);
      press(16, 2, 15);
    end
    chk("score_before_timeout", int'(score), 3);

    // timeout
    collect(2);
    tgt = n_res + 1;
    push_exp(0, 1, 0, 15, cyc + 2);
    answer_window = 1'b0;
    wait_res(tgt);
    answer_window = 1'b1;
    tick(); tick();
    chk("timeout_held", int'(timeout), 1);
    chk("timeout_led", int'(score_led), 7'b0000011);

    // abort after third operand, then round_start with coincident operand
    start_round();
    send_ops(5, 0, 3);
    chk("partial_sum", int'(round_sum), 18);
    start_round();
    chk("abort_sum", int'(round_sum), 0);
    num_valid = 1'b1; num_in = 5'd31;
    start_round();
    num_valid = 1'b0;
    chk("start_beats_operand", int'(round_sum), 0);
    send_ops(5, 0, 5);
    chk("count_restarted_sum", int'(round_sum), 35);
    chk("abort_score_kept", int'(score), 2);
    press(35, 2, 35);

    // submit pressed during COLLECT is discarded
    start_round();
    send_ops(1, 0, 2);
    tgt = n_res;
    answer_in = 8'd155;
    submit = 1'b1;
    tick(); tick(); tick();
    submit = 1'b0;
    tick();
    send_ops(1, 2, 5);
    for (int i = 0; i < 6; i++) tick();
    chk("collect_submit_no_result", n_res, tgt);
    chk("still_waiting", int'(busy), 1);
    press(155, 2, 155);
    chk("score_4", int'(score), 4);

    // async reset while in CHECK
    collect(4);
    answer_in = 8'd66;
    submit = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("midrst_score", int'(score), 0);
    chk("midrst_led", int'(score_led), 0);
    chk("midrst_sum", int'(round_sum), 0);
    chk("midrst_answer", int'(answer_latched), 0);
    chk("midrst_flags", int'({result_valid, correct, timeout, busy}), 0);
    submit = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_score = 0;
    tick();
    chk("idle_after_reset", int'(busy), 0);
    collect(3);
    press(0, 2, 0);
    chk("post_reset_score", int'(score), 1);

    // submit edge coincides with the window falling: edge wins
    collect(0);
    tgt = n_res + 1;
    answer_in = 8'd60;
    push_exp(1, 0, 60, 60, cyc + 4);
    submit = 1'b1;
    tick(); tick();
    answer_window = 1'b0;
    tick();
    answer_window = 1'b1;
    submit = 1'b0;
    wait_res(tgt);
    tick(); tick();
    chk("coincident_no_timeout", int'(timeout), 0);
    chk("pending_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
